// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32 opcode constants, fetch FSM states and reset vector
package rv32_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    // R-type / I-type
    localparam logic [6:0] OP_OP     = 7'h33;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_JALR   = 7'h67;
    // S / B / J / U
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    // ENV
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/ifu32_if.sv
// rtl/ifu32_if.sv - fetch unit signal bundle: redirect, imem request/response, decode handshake
interface ifu32_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [6:0]  out_opcode;
    logic [3:0]  out_funct3;
    logic [7:0]  out_funct7;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;

    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
        output imem_req_valid, imem_req_addr, out_valid, out_pc, out_inst,
               out_opcode, out_funct3, out_funct7, out_rd, out_rs1, out_rs2
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
        input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_inst,
               out_opcode, out_funct3, out_funct7, out_rd, out_rs1, out_rs2
    );
endinterface

// File: rtl/fetch_fifo2.sv
// rtl/fetch_fifo2.sv - two-entry {pc, inst} buffer with push, pop, flush and occupancy count
module fetch_fifo2 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        push,
    input  logic [63:0] push_data,
    input  logic        pop,
    output logic [63:0] head_data,
    output logic [1:0]  count
);

    logic [63:0] ent0_q, ent0_d;
    logic [63:0] ent1_q, ent1_d;
    logic        wr_q, wr_d;
    logic        rd_q, rd_d;
    logic [1:0]  count_q, count_d;
    logic        do_push;
    logic        do_pop;

    // A push into a full buffer is legal only when the head leaves in the same cycle.
    assign do_push = push && ((count_q != 2'd2) || pop);
    assign do_pop  = pop && (count_q != 2'd0);

    always_comb begin
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (flush) begin
            wr_d    = 1'b0;
            rd_d    = 1'b0;
            count_d = 2'd0;
        end else begin
            if (do_push) begin
                if (wr_q) ent1_d = push_data;
                else      ent0_d = push_data;
                wr_d = ~wr_q;
            end
            if (do_pop) rd_d = ~rd_q;
            count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            count_q <= 2'd0;
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    assign head_data = rd_q ? ent1_q : ent0_q;
    assign count     = count_q;

endmodule

// File: rtl/ifu32.sv
// rtl/ifu32.sv - RV32 instruction fetch unit with single outstanding request and 2-entry output buffer
module ifu32
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic [6:0]  out_opcode,
    output logic [3:0]  out_funct3,
    output logic [7:0]  out_funct7,
    output logic [4:0]  out_rd,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2
);

    localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  pend_pc_q, pend_pc_d;
    fetch_state_e state_q, state_d;
    logic [1:0]   count;
    logic [63:0]  head_data;
    logic [63:0]  push_data;
    logic         push;
    logic         pop;
    logic         req_fire;

    // Gated by rst_n so no request is presented while reset is held.
    assign imem_req_valid = rst_n && (state_q == ST_RUN) && (count < DEPTH) && !redirect_valid;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pend_pc_d  = pend_pc_q;
        push       = 1'b0;
        push_data  = {pend_pc_q, imem_rsp_data};
        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            pend_pc_d  = fetch_pc_q;
        end
        case (state_q)
            ST_RUN: begin
                // A same-cycle response completes the fetch without leaving RUN.
                if (req_fire) begin
                    if (imem_rsp_valid) begin
                        push      = 1'b1;
                        push_data = {fetch_pc_q, imem_rsp_data};
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    state_d = ST_RUN;
                    push    = !redirect_valid;
                end else if (redirect_valid) begin
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (imem_rsp_valid) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
        if (redirect_valid) fetch_pc_d = redirect_pc & ~32'd3;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= RESET_PC;
            pend_pc_q  <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pend_pc_q  <= pend_pc_d;
        end
    end

    assign pop = out_valid && out_ready && !redirect_valid;

    fetch_fifo2 u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head_data (head_data),
        .count     (count)
    );

    assign out_valid  = (count != 2'd0);
    assign out_pc     = head_data[63:32];
    assign out_inst   = head_data[31:0];
    assign out_opcode = out_inst[6:0];
    assign out_rd     = out_inst[11:7];
    assign out_funct3 = {1'b0, out_inst[14:12]};
    assign out_rs1    = out_inst[19:15];
    assign out_rs2    = out_inst[24:20];
    assign out_funct7 = {1'b0, out_inst[31:25]};

endmodule

// File: tb/tb_ifu32.sv
// tb/tb_ifu32.sv - directed vector bench for ifu32
module tb_ifu32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ifu32_if bus ();

    logic        lat0;
    logic [31:0] inst_const;
    logic        rsp_manual;
    logic [31:0] rsp_manual_data;

    always_comb begin
        bus.imem_rsp_valid = lat0 ? (bus.imem_req_valid && bus.imem_req_ready) : rsp_manual;
        bus.imem_rsp_data  = lat0 ? inst_const : rsp_manual_data;
    end

    ifu32 dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (bus.redirect_valid),
        .redirect_pc    (bus.redirect_pc),
        .imem_req_valid (bus.imem_req_valid),
        .imem_req_ready (bus.imem_req_ready),
        .imem_req_addr  (bus.imem_req_addr),
        .imem_rsp_valid (bus.imem_rsp_valid),
        .imem_rsp_data  (bus.imem_rsp_data),
        .out_valid      (bus.out_valid),
        .out_ready      (bus.out_ready),
        .out_pc         (bus.out_pc),
        .out_inst       (bus.out_inst),
        .out_opcode     (bus.out_opcode),
        .out_funct3     (bus.out_funct3),
        .out_funct7     (bus.out_funct7),
        .out_rd         (bus.out_rd),
        .out_rs1        (bus.out_rs1),
        .out_rs2        (bus.out_rs2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] exp_pc;
        logic [6:0]  op;
        logic [3:0]  f3;
        logic [7:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'h0000_1000, 32'h40B5_0533, 32'h0000_1000, 7'h33, 4'h0, 8'h20, 5'd10, 5'd10, 5'd11};
        vecs[1] = '{32'h0000_2006, 32'h0000_0013, 32'h0000_2004, 7'h13, 4'h0, 8'h00, 5'd0,  5'd0,  5'd0};
        vecs[2] = '{32'h8000_0010, 32'hFFFF_FFFF, 32'h8000_0010, 7'h7F, 4'h7, 8'h7F, 5'd31, 5'd31, 5'd31};
        vecs[3] = '{32'h7FFF_FFF1, 32'h00A0_0093, 32'h7FFF_FFF0, 7'h13, 4'h0, 8'h00, 5'd1,  5'd0,  5'd10};
        vecs[4] = '{32'h0000_0100, 32'h00B5_0463, 32'h0000_0100, 7'h63, 4'h0, 8'h00, 5'd8,  5'd10, 5'd11};
        vecs[5] = '{32'hDEAD_BEE3, 32'h0000_A303, 32'hDEAD_BEE0, 7'h03, 4'h2, 8'h00, 5'd6,  5'd1,  5'd0};

        rst_n = 1'b0;
        lat0 = 1'b1;
        inst_const = 32'h0000_0013;
        rsp_manual = 1'b0;
        rsp_manual_data = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.imem_req_ready = 1'b1;
        bus.out_ready = 1'b0;

        tick();
        tick();
        chk("reset_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);

        // First fetches after reset with zero-latency memory, decode held off.
        rst_n = 1'b1;
        #1;
        chk("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("first_req_addr", bus.imem_req_addr, 32'h8000_0000);
        tick();
        chk("first_out_valid", 32'(bus.out_valid), 32'd1);
        chk("first_out_pc", bus.out_pc, 32'h8000_0000);
        chk("first_out_opcode", 32'(bus.out_opcode), 32'h13);
        chk("second_req_addr", bus.imem_req_addr, 32'h8000_0004);
        chk("second_req_valid", 32'(bus.imem_req_valid), 32'd1);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("full_req_valid", 32'(bus.imem_req_valid), 32'd0);
            chk("full_out_pc", bus.out_pc, 32'h8000_0000);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            chk("drain_out_valid", 32'(bus.out_valid), 32'd1);
            chk("drain_out_pc", bus.out_pc, 32'h8000_0000 + 32'(4 * i));
            tick();
        end

        // Redirect while a request is outstanding; the late response must be dropped.
        lat0 = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h8000_0040;
        tick();
        bus.redirect_valid = 1'b0;
        bus.imem_req_ready = 1'b1;
        #1;
        chk("wait_req_addr", bus.imem_req_addr, 32'h8000_0040);
        chk("wait_out_valid", 32'(bus.out_valid), 32'd0);
        tick();
        chk("wait_req_valid", 32'(bus.imem_req_valid), 32'd0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h8000_0102;
        tick();
        bus.redirect_valid = 1'b0;
        rsp_manual = 1'b1;
        rsp_manual_data = 32'h1234_5678;
        #1;
        chk("drop_req_valid", 32'(bus.imem_req_valid), 32'd0);
        tick();
        rsp_manual = 1'b0;
        #1;
        chk("drop_out_valid", 32'(bus.out_valid), 32'd0);
        chk("drop_req_valid_after", 32'(bus.imem_req_valid), 32'd1);
        chk("drop_req_addr", bus.imem_req_addr, 32'h8000_0100);

        // Redirect together with a WAIT response and a decode pop.
        bus.out_ready = 1'b0;
        tick();
        rsp_manual = 1'b1;
        rsp_manual_data = 32'h0000_0033;
        tick();
        rsp_manual = 1'b0;
        #1;
        chk("coin_pre_out_pc", bus.out_pc, 32'h8000_0100);
        chk("coin_pre_req_addr", bus.imem_req_addr, 32'h8000_0104);
        tick();
        bus.out_ready = 1'b1;
        rsp_manual = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0000_2000;
        #1;
        chk("coin_out_valid_before", 32'(bus.out_valid), 32'd1);
        tick();
        bus.redirect_valid = 1'b0;
        rsp_manual = 1'b0;
        #1;
        chk("coin_out_valid", 32'(bus.out_valid), 32'd0);
        chk("coin_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("coin_req_addr", bus.imem_req_addr, 32'h0000_2000);

        // Fetch PC wraps past the top of the address space.
        lat0 = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        chk("wrap_req_addr0", bus.imem_req_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_req_addr1", bus.imem_req_addr, 32'h0000_0000);
        chk("wrap_out_pc", bus.out_pc, 32'hFFFF_FFFC);

        // Decode field table.
        for (int v = 0; v < 6; v++) begin
            bus.out_ready = 1'b0;
            bus.redirect_valid = 1'b1;
            bus.redirect_pc = vecs[v].pc;
            inst_const = vecs[v].inst;
            tick();
            bus.redirect_valid = 1'b0;
            #1;
            chk("vec_req_addr", bus.imem_req_addr, vecs[v].exp_pc);
            tick();
            chk("vec_out_valid", 32'(bus.out_valid), 32'd1);
            chk("vec_out_pc", bus.out_pc, vecs[v].exp_pc);
            chk("vec_out_inst", bus.out_inst, vecs[v].inst);
            chk("vec_opcode", 32'(bus.out_opcode), 32'(vecs[v].op));
            chk("vec_funct3", 32'(bus.out_funct3), 32'(vecs[v].f3));
            chk("vec_funct7", 32'(bus.out_funct7), 32'(vecs[v].f7));
            chk("vec_rd", 32'(bus.out_rd), 32'(vecs[v].rd));
            chk("vec_rs1", 32'(bus.out_rs1), 32'(vecs[v].rs1));
            chk("vec_rs2", 32'(bus.out_rs2), 32'(vecs[v].rs2));
        end

        // Reset while a request is outstanding; a response during reset is ignored.
        lat0 = 1'b0;
        bus.out_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0000_3000;
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        chk("rstwait_req_addr", bus.imem_req_addr, 32'h0000_3000);
        tick();
        chk("rstwait_req_valid", 32'(bus.imem_req_valid), 32'd0);
        rst_n = 1'b0;
        rsp_manual = 1'b1;
        rsp_manual_data = 32'h0000_0013;
        #1;
        chk("rstmid_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rstmid_out_valid", 32'(bus.out_valid), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        rsp_manual = 1'b0;
        #1;
        chk("rstrel_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("rstrel_req_addr", bus.imem_req_addr, 32'h8000_0000);
        tick();
        chk("rstrel_out_valid", 32'(bus.out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifu32.md
IFU32 -- requirements
Module: ifu32

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, meaning first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, fixed at 2, meaning output buffer entries.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-006 SHALL have port redirect_pc  input  32  redirect target.
REQ-007 SHALL have ports imem_req_valid output 1, imem_req_ready input 1, imem_req_addr output 32: fetch request handshake.
REQ-008 SHALL have ports imem_rsp_valid input 1, imem_rsp_data input 32: fetch response, no backpressure.
REQ-009 SHALL have ports out_valid output 1, out_ready input 1: decode-side handshake.
REQ-010 SHALL have ports out_pc output 32, out_inst output 32: head-entry PC and instruction word.
REQ-011 SHALL have ports out_opcode output 7, out_funct3 output 4, out_funct7 output 8, out_rd/out_rs1/out_rs2 output 5 each: fields for the decode stage.

Function
REQ-012 SHALL hold a fetch PC register; on accepted request (req_valid && req_ready) it advances by 4 and the issued address is latched as the pending PC.
REQ-013 SHALL run FSM RUN/WAIT/DROP: RUN = no request outstanding; WAIT = one outstanding to keep; DROP = one outstanding to discard.
REQ-014 SHALL assert imem_req_valid only in RUN, with (fifo_count + 0) < 2 and redirect_valid low; imem_req_addr = fetch PC.
REQ-015 SHALL transition RUN->WAIT on accepted request; WAIT->RUN on imem_rsp_valid, pushing {pending PC, imem_rsp_data}.
REQ-016 SHALL, on redirect in WAIT without response, go to DROP; in DROP, imem_rsp_valid discards the data and returns to RUN.
REQ-017 SHALL, on redirect coinciding with a WAIT response, discard that response and go to RUN.
REQ-018 SHALL, on redirect in any state: flush FIFO, load fetch PC with {redirect_pc[31:2],2'b00}; out_valid low next cycle; redirect in DROP stays DROP.
REQ-019 SHALL pop the FIFO head on out_valid && out_ready; simultaneous push and pop SHALL keep count unchanged; redirect overrides both.
REQ-020 SHALL present FIFO head combinationally: out_valid = count!=0; outputs stable while out_valid && !out_ready.
REQ-021 SHALL extract out_opcode=inst[6:0], out_rd=inst[11:7], out_funct3={1'b0,inst[14:12]}, out_rs1=inst[19:15], out_rs2=inst[24:20], out_funct7={1'b0,inst[31:25]}.
REQ-022 SHALL guarantee FIFO never overflows: issue only with count<=1, at most one outstanding.
REQ-023 SHALL achieve one instruction per cycle steady state only if memory responds same cycle; otherwise throughput bounded by one outstanding request.
REQ-024 SHALL wrap fetch PC modulo 2^32 (32'hFFFF_FFFC + 4 = 0).

Reset
REQ-025 SHALL, while rst_n low: fetch PC=RESET_PC, state=RUN, FIFO empty, out_valid=0, imem_req_valid=0.
REQ-026 SHALL issue first request at RESET_PC in the first cycle after rst_n deasserts; reset mid-WAIT abandons the request, and a late response after reset SHALL be ignored only if arriving during reset.

Structure
REQ-027 SHALL place opcode constants (R/I/S/B/J/U/ENV groups), FSM state enum, and RESET_PC default in shared package rv32_pkg.
REQ-028 SHALL implement the 2-entry buffer as sub-module fetch_fifo2 (64-bit entries, push/pop/flush, count).

Verification
REQ-029 Reset release, req_ready=1, zero-latency rsp 0x00000013 -> requests at 0x80000000, 0x80000004; out_opcode=0x13, out_pc=0x80000000.
REQ-030 out_ready=0 for 5 cycles -> exactly 2 entries buffered, req_valid low, no lost or duplicated PC after release.
REQ-031 Redirect to 0x80000102 during WAIT, rsp next cycle -> rsp discarded, next request addr 0x80000100, FIFO empty.
REQ-032 Redirect coinciding with rsp and out pop -> FIFO empty next cycle, state RUN, request at redirect target.
REQ-033 Instruction 0x40B50533 (sub) -> opcode 0x33, funct3 0x0, funct7 0x20, rd 10, rs1 10, rs2 11.
REQ-034 Redirect to 0xFFFFFFFC, two fetches -> addresses 0xFFFFFFFC then 0x00000000.
